// File: rtl/core_pkg.sv
// Shared core definitions: pipeline-control state encoding, register-address width,
// the canonical NOP and the load-use hazard compare.
package core_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic {
    HZ_RUN,
    HZ_FLUSH
  } hz_state_e;

  // A load in EX feeds a register the ID instruction actually reads; x0 never carries a dependency.
  function automatic logic is_load_use(
    input logic                  mem_rden_ex,
    input logic [REG_ADDR_W-1:0] rd_ex,
    input logic [REG_ADDR_W-1:0] rs1_id,
    input logic                  rs1_used,
    input logic [REG_ADDR_W-1:0] rs2_id,
    input logic                  rs2_used
  );
    return mem_rden_ex && (rd_ex != '0) &&
           ((rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous active-high clear.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: drives PC / IF-ID / ID-EX enables and active-low flushes
// from a fixed priority of dmem freeze, redirect, flush window, load-use and imem bubble.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_id,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_id,
  input  logic                  i_rs1_used_id,
  input  logic                  i_rs2_used_id,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_ex,
  input  logic                  i_mem_rden_ex,
  input  logic                  i_redirect_ex,
  input  logic                  i_dmem_busy,
  input  logic                  i_imem_ready,
  output logic                  o_enable_pc,
  output logic                  o_enable_if,
  output logic                  o_rst_if,
  output logic                  o_enable_id,
  output logic                  o_rst_id,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  localparam int FCNT_W = 3;

  hz_state_e         state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              load_use;

  assign load_use = is_load_use(i_mem_rden_ex, i_rd_addr_ex, i_rs1_addr_id, i_rs1_used_id,
                                i_rs2_addr_id, i_rs2_used_id);

  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path infers a latch.
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    o_enable_pc = 1'b1;
    o_enable_if = 1'b1;
    o_rst_if    = 1'b1;
    o_enable_id = 1'b1;
    o_rst_id    = 1'b1;

    if (i_rst) begin
      o_rst_if = 1'b0;
      o_rst_id = 1'b0;
    end else if (i_dmem_busy) begin
      // EX is frozen, so a pending redirect stays asserted and is taken once busy drops.
      o_enable_pc = 1'b0;
      o_enable_if = 1'b0;
      o_enable_id = 1'b0;
    end else if (i_redirect_ex) begin
      o_rst_if = 1'b0;
      o_rst_id = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_d = HZ_FLUSH;
        fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
      end else begin
        state_d = HZ_RUN;
      end
    end else if (state_q == HZ_FLUSH) begin
      o_rst_if = 1'b0;
      fcnt_d   = fcnt_q - FCNT_W'(1);
      if (fcnt_q == FCNT_W'(1)) state_d = HZ_RUN;
    end else if (load_use) begin
      o_enable_pc = 1'b0;
      o_enable_if = 1'b0;
      o_rst_id    = 1'b0;
    end else if (!i_imem_ready) begin
      o_enable_pc = 1'b0;
      o_rst_if    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= HZ_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (!i_rst && !o_enable_pc),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (!i_rst && !o_rst_if),
    .o_cnt (o_flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a behavioural model of the priority table predicts
// pc/en_if/rst_if/en_id/rst_id and both counters for every cycle.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int FC   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, busy, redir, imem, mrd, u1, u2;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic                  en_pc, en_if, rst_if, en_id, rst_id;
  logic [CW-1:0]         stall_cnt, flush_cnt;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rs1_addr_id (rs1),
    .i_rs2_addr_id (rs2),
    .i_rs1_used_id (u1),
    .i_rs2_used_id (u2),
    .i_rd_addr_ex  (rd),
    .i_mem_rden_ex (mrd),
    .i_redirect_ex (redir),
    .i_dmem_busy   (busy),
    .i_imem_ready  (imem),
    .o_enable_pc   (en_pc),
    .o_enable_if   (en_if),
    .o_rst_if      (rst_if),
    .o_enable_id   (en_id),
    .o_rst_id      (rst_id),
    .o_stall_cnt   (stall_cnt),
    .o_flush_cnt   (flush_cnt)
  );

  typedef struct packed {
    logic       rst, busy, redir, imem, mrd;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
  } stim_t;

  typedef struct packed {
    logic [4:0]    ctl;
    logic [CW-1:0] stall, flush;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  bit m_flush = 1'b0;
  int m_cnt   = 0;
  int m_stall = 0;
  int m_fl    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t t;
    t      = '0;
    t.imem = 1'b1;
    return t;
  endfunction

  // Outputs packed as {pc, en_if, rst_if, en_id, rst_id}
  function automatic logic [4:0] model_ctl(input stim_t s);
    logic lu;
    lu = s.mrd && (s.rd != 5'd0) &&
         ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
    if (s.rst)        return 5'b11010;
    else if (s.busy)  return 5'b00101;
    else if (s.redir) return 5'b11010;
    else if (m_flush) return 5'b11011;
    else if (lu)      return 5'b00110;
    else if (!s.imem) return 5'b01011;
    else              return 5'b11111;
  endfunction

  task automatic model_update(input stim_t s, input logic [4:0] ctl);
    if (s.rst) begin
      m_flush = 1'b0;
      m_cnt   = 0;
      m_stall = 0;
      m_fl    = 0;
    end else begin
      if (!ctl[4] && m_stall < CMAX) m_stall++;
      if (!ctl[2] && m_fl < CMAX)    m_fl++;
      if (s.busy) begin
      end else if (s.redir) begin
        m_flush = (FC > 1);
        m_cnt   = FC - 1;
      end else if (m_flush) begin
        if (m_cnt == 1) m_flush = 1'b0;
        m_cnt--;
      end
    end
  endtask

  task automatic drive(input stim_t s);
    rst   = s.rst;   busy = s.busy; redir = s.redir; imem = s.imem; mrd = s.mrd;
    rd    = s.rd;    rs1  = s.rs1;  rs2   = s.rs2;   u1   = s.u1;   u2  = s.u2;
  endtask

  // One cycle: drive after the edge, predict, compare on the falling edge, advance the model.
  task automatic step(input stim_t s, input string tag);
    exp_t e, got;
    drive(s);
    e.ctl   = model_ctl(s);
    e.stall = CW'(m_stall);
    e.flush = CW'(m_fl);
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    check({tag, ".ctl"},   32'({en_pc, en_if, rst_if, en_id, rst_id}), 32'(got.ctl));
    check({tag, ".stall"}, 32'(stall_cnt), 32'(got.stall));
    check({tag, ".flush"}, 32'(flush_cnt), 32'(got.flush));
    model_update(s, got.ctl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    s     = idle();
    s.rst = 1'b1;
    drive(s);
    @(posedge clk);
    #1;

    // Reset cycles, then idle with imem ready
    step(s, "rst0");
    step(s, "rst1");
    s = idle();
    step(s, "idle0");
    step(s, "idle1");

    // lw x5 in EX, add x6,x5,x7 in ID
    s = idle(); s.mrd = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; s.rs2 = 7; s.u2 = 1;
    step(s, "lu_rs1");
    s = idle();
    step(s, "lu_after");
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Load to x0 never stalls; an unused matching rs1 never stalls; rs2 match does
    s = idle(); s.mrd = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
    step(s, "lu_x0");
    s = idle(); s.mrd = 1; s.rd = 9; s.rs1 = 9; s.u1 = 0;
    step(s, "lu_unused");
    s = idle(); s.mrd = 1; s.rd = 12; s.rs2 = 12; s.u2 = 1;
    step(s, "lu_rs2");

    // Single-cycle redirect opens a three-cycle IF/ID flush window
    s = idle(); s.rst = 1;
    step(s, "rst2");
    s = idle(); s.redir = 1;
    step(s, "redir");
    s = idle();
    step(s, "flush1");
    step(s, "flush2");
    step(s, "post_flush");
    check("flush_cnt3", 32'(flush_cnt), 32'd3);

    // dmem busy masks redirect and load-use for four cycles, then redirect wins
    s = idle(); s.busy = 1; s.redir = 1; s.mrd = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1;
    for (int i = 0; i < 4; i++) step(s, "busy");
    s.busy = 0;
    step(s, "busy_redir");
    s = idle(); s.mrd = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1;
    step(s, "flush_lu");
    s = idle(); s.redir = 1;
    step(s, "redir_in_flush");
    s = idle(); s.busy = 1;
    step(s, "busy_in_flush");
    s = idle(); s.imem = 0;
    step(s, "flush_imem");
    step(s, "flush_imem2");
    step(s, "imem_bubble");

    // Stall counter saturation, then reset mid-flush
    s = idle(); s.rst = 1;
    step(s, "rst3");
    s = idle(); s.imem = 0;
    for (int i = 0; i < 20; i++) step(s, "nrdy");
    check("stall_sat", 32'(stall_cnt), 32'd15);
    s = idle(); s.redir = 1;
    step(s, "redir2");
    s = idle(); s.rst = 1;
    step(s, "rst_mid_flush");
    s = idle();
    step(s, "after_rst");
    check("rst_stall_clr", 32'(stall_cnt), 32'd0);

    // Mixed random traffic
    for (int i = 0; i < 400; i++) begin
      s       = idle();
      s.rst   = ($urandom_range(0, 59) == 0);
      s.busy  = ($urandom_range(0, 6) == 0);
      s.redir = ($urandom_range(0, 7) == 0);
      s.imem  = ($urandom_range(0, 5) != 0);
      s.mrd   = ($urandom_range(0, 2) == 0);
      s.rd    = 5'($urandom_range(0, 3));
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      step(s, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
